// File: rtl/mem_responder_pkg.sv
// Shared constants, FSM encoding and address checking for the memory responder.
// Imported by the bus interface, the responder top and its word array.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int CNT_W      = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFS_W = 2;

    // Misaligned byte offset, or any address bit above the word-index field.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr, input int depth_log2);
        logic misaligned;
        logic out_of_range;
        misaligned   = |addr[BYTE_OFS_W-1:0];
        out_of_range = ((addr >> (depth_log2 + BYTE_OFS_W)) != '0);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator/responder bus for the memory responder.
// Handshake: the master raises req with wr/addr/wdata and holds req high until it sees
// ack; ack is a single-cycle pulse, and rdata/err are meaningful only while ack=1.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (output req, wr, addr, wdata, input rdata, ack, err);
    modport slave  (input req, wr, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word array: synchronous write, asynchronous (combinational) read.
// Contents are never reset.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: captures a request, waits WAIT_CYCLES,
// then commits the write or loads read data and pulses ack (with err on bad addresses).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus,
    output state_t           o_state
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_err;

    logic                  w_capture;
    logic                  w_enter_ack;
    logic                  w_wr;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_err;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_word;
    logic [DATA_W-1:0]     w_mem_rdata;

    assign w_capture   = (r_state == ST_IDLE) && bus.req;
    assign w_enter_ack = (w_capture && (WAIT_CYCLES == 0)) ||
                         ((r_state == ST_BUSY) && (r_cnt == CNT_ONE));

    // With zero wait states the commit edge is the capture edge, so use the live bus.
    assign w_wr    = w_capture ? bus.wr    : r_wr;
    assign w_addr  = w_capture ? bus.addr  : r_addr;
    assign w_wdata = w_capture ? bus.wdata : r_wdata;

    assign w_err  = addr_error(w_addr, DEPTH_LOG2);
    assign w_word = w_addr[DEPTH_LOG2+1:BYTE_OFS_W];
    assign w_we   = w_enter_ack && w_wr && !w_err && !reset;

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_word),
        .i_wdata (w_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_wr    <= bus.wr;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_ack) begin
                r_ack <= 1'b1;
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!w_wr) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign o_state   = r_state;

endmodule
